// File: rtl/conv_line_buffer.sv
// -----------------------------------------------------------------------------
// conv_line_buffer
//
// Purpose:
//   Raster-order line buffer that feeds a 3x3 convolution. It keeps the two
//   previous image rows in block-RAM-style line memories. For every accepted
//   pixel it emits the 3-row column {row r-2, row r-1, row r} at the current
//   column, one cycle later.
//
//   Frames are delimited implicitly by pixel count. i_done can also end a frame
//   early. Rows 0 and 1 of each frame only prime the line memories and never
//   produce o_valid, so stale line data from a previous frame (or from before
//   a reset) can never reach the output as valid.
//
// Parameters:
//   IMG_WIDTH  - pixels per row (>= 2)
//   IMG_HEIGHT - rows per image (>= 3)
//
// Ports:
//   clk        in   1   single clock, rising edge
//   reset      in   1   synchronous, active-high
//   i_valid    in   1   i_data carries a pixel this cycle
//   i_done     in   1   final pixel of current image (qualified by i_valid)
//   i_data     in   8   unsigned pixel, raster order
//   o_valid    out  1   o_data holds a valid 3-row column
//   o_img_done out  1   single-cycle end-of-image pulse
//   o_data     out  24  [23:16] row r-2, [15:8] row r-1, [7:0] row r
// -----------------------------------------------------------------------------
module conv_line_buffer #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  input  logic        i_done,
  input  logic [7:0]  i_data,
  output logic        o_valid,
  output logic        o_img_done,
  output logic [23:0] o_data
);

  localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [ROW_W-1:0] ROW_TWO = ROW_W'(2);

  // Position of the pixel currently presented on i_data.
  logic [COL_W-1:0] col_reg;
  logic [COL_W-1:0] col_next;
  logic [ROW_W-1:0] row_reg;
  logic [ROW_W-1:0] row_next;

  // line1 holds row r-1 and line2 holds row r-2, both indexed by column.
  // These memories are deliberately not reset. The row >= 2 gate keeps their
  // stale contents off the valid output.
  logic [7:0] line1_mem [IMG_WIDTH];
  logic [7:0] line2_mem [IMG_WIDTH];

  logic        o_valid_reg;
  logic        o_img_done_reg;
  logic [23:0] o_data_reg;

  logic col_last;
  logic frame_end;

  assign col_last  = (col_reg == COL_MAX);
  // The natural end of the raster and an early i_done both end the frame.
  assign frame_end = i_done | (col_last & (row_reg == ROW_MAX));

  always_comb begin
    col_next = col_reg;
    row_next = row_reg;
    if (frame_end) begin
      col_next = '0;
      row_next = '0;
    end else if (col_last) begin
      col_next = '0;
      row_next = row_reg + ROW_W'(1);
    end else begin
      col_next = col_reg + COL_W'(1);
    end
  end

  // Counters and registered outputs. o_data is the registered read port of
  // both line memories, so the read is read-before-write: it returns the old
  // contents at the column being written this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_reg        <= '0;
      row_reg        <= '0;
      o_valid_reg    <= 1'b0;
      o_img_done_reg <= 1'b0;
      o_data_reg     <= '0;
    end else if (i_valid) begin
      col_reg        <= col_next;
      row_reg        <= row_next;
      o_valid_reg    <= (row_reg >= ROW_TWO);
      o_img_done_reg <= frame_end;
      o_data_reg     <= {line2_mem[col_reg], line1_mem[col_reg], i_data};
    end else begin
      // Idle cycle: the pulses drop and o_data keeps its previous value.
      o_valid_reg    <= 1'b0;
      o_img_done_reg <= 1'b0;
    end
  end

  // Line memory writes. Row r-1 shifts into the r-2 slot and the new pixel
  // takes the r-1 slot. A pixel presented during reset is discarded.
  always_ff @(posedge clk) begin
    if (i_valid && !reset) begin
      line2_mem[col_reg] <= line1_mem[col_reg];
      line1_mem[col_reg] <= i_data;
    end
  end

  assign o_valid    = o_valid_reg;
  assign o_img_done = o_img_done_reg;
  assign o_data     = o_data_reg;

endmodule

// File: tb/tb_conv_line_buffer.sv
// -----------------------------------------------------------------------------
// tb_conv_line_buffer
//
// Self-checking bench for conv_line_buffer with a 4x4 image. Each driven cycle
// pushes its expected outputs to a scoreboard queue. The expected values come
// from a frame-store reference model. The entry is popped and compared just
// after the clock edge that produces the DUT output.
// -----------------------------------------------------------------------------
module tb_conv_line_buffer;

  localparam int W = 4;
  localparam int H = 4;

  logic        clk;
  logic        reset;
  logic        i_valid;
  logic        i_done;
  logic [7:0]  i_data;
  logic        o_valid;
  logic        o_img_done;
  logic [23:0] o_data;

  conv_line_buffer #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .i_valid   (i_valid),
    .i_done    (i_done),
    .i_data    (i_data),
    .o_valid   (o_valid),
    .o_img_done(o_img_done),
    .o_data    (o_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        d;
    logic [23:0] data;
    logic        known;
  } exp_t;

  exp_t        exp_q[$];
  logic [23:0] got_q[$];
  int          done_cnt;
  int          n_tests;
  int          n_fail;

  // Reference model: the pixels of the current frame, stored by position.
  logic [7:0]  img [H][W];
  int          m_row;
  int          m_col;
  logic [23:0] last_data;
  logic        last_known;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle, push its expectation, and compare after the edge.
  task automatic cyc(input logic v, input logic d, input logic [7:0] px, input logic rst);
    exp_t e;
    exp_t p;
    reset   = rst;
    i_valid = v;
    i_done  = d;
    i_data  = px;
    if (rst) begin
      e = '{v: 1'b0, d: 1'b0, data: 24'h0, known: 1'b1};
      m_row = 0;
      m_col = 0;
    end else if (v) begin
      e.v = (m_row >= 2);
      e.d = d || (m_row == H-1 && m_col == W-1);
      img[m_row][m_col] = px;
      if (e.v) begin
        e.data  = {img[m_row-2][m_col], img[m_row-1][m_col], px};
        e.known = 1'b1;
      end else begin
        e.data  = 24'h0;
        e.known = 1'b0;
      end
      if (e.d) begin
        m_row = 0;
        m_col = 0;
      end else if (m_col == W-1) begin
        m_col = 0;
        m_row = m_row + 1;
      end else begin
        m_col = m_col + 1;
      end
    end else begin
      e = '{v: 1'b0, d: 1'b0, data: last_data, known: last_known};
    end
    last_data  = e.data;
    last_known = e.known;
    exp_q.push_back(e);

    @(posedge clk);
    #1;
    p = exp_q.pop_front();
    check("o_valid", 32'(o_valid), 32'(p.v));
    check("o_img_done", 32'(o_img_done), 32'(p.d));
    if (p.known) check("o_data", 32'(o_data), 32'(p.data));
    if (o_valid) begin
      got_q.push_back(o_data);
      $display("[TB] out #%0d data=0x%06h img_done=%0d", got_q.size(), o_data, o_img_done);
    end
    if (o_img_done) done_cnt++;
  endtask

  // Stream a 4x4 frame whose pixel values are off + 16*row + col.
  // gap: insert an idle cycle between pixels. stop_at: the last pixel index
  // sent (i_done is set on it when stop_done). idle_done_at: an idle cycle
  // with i_done=1 is placed before that pixel index.
  task automatic stream(input logic [7:0] off, input int gap, input int stop_at,
                        input logic stop_done, input int idle_done_at);
    for (int k = 0; k < W*H; k++) begin
      if (k == idle_done_at) cyc(1'b0, 1'b1, 8'hEE, 1'b0);
      if (gap != 0 && k > 0) cyc(1'b0, 1'b0, 8'h55, 1'b0);
      cyc(1'b1, (k == stop_at) && stop_done, off + 8'(16*(k/W) + k%W), 1'b0);
      if (k == stop_at) break;
    end
  endtask

  function automatic logic [23:0] col_vec(input logic [7:0] off, input int k);
    int r;
    int c;
    r = 2 + k / W;
    c = k % W;
    return {off + 8'(16*(r-2) + c), off + 8'(16*(r-1) + c), off + 8'(16*r + c)};
  endfunction

  task automatic clear_stats();
    got_q.delete();
    done_cnt = 0;
  endtask

  task automatic check_frame_seq(input string tag, input logic [7:0] off);
    check({tag, "_count"}, 32'(got_q.size()), 32'd8);
    for (int k = 0; k < 8 && k < got_q.size(); k++)
      check({tag, "_col"}, 32'(got_q[k]), 32'(col_vec(off, k)));
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    done_cnt = 0;
    m_row = 0;
    m_col = 0;
    last_data = 24'h0;
    last_known = 1'b0;
    reset = 1'b1;
    i_valid = 1'b0;
    i_done = 1'b0;
    i_data = 8'h00;

    // Reset, with pixels presented that must be discarded.
    cyc(1'b1, 1'b0, 8'hAA, 1'b1);
    cyc(1'b1, 1'b1, 8'hBB, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);

    // Full frame, continuous.
    clear_stats();
    stream(8'h00, 0, -1, 1'b0, -1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    check("a_count", 32'(got_q.size()), 32'd8);
    if (got_q.size() == 8) begin
      check("a_first", 32'(got_q[0]), 32'h001020);
      check("a_2_1", 32'(got_q[1]), 32'h011121);
      check("a_last", 32'(got_q[7]), 32'h132333);
    end
    check("a_done_cnt", 32'(done_cnt), 32'd1);

    // Same frame with i_valid deasserted every other cycle.
    clear_stats();
    stream(8'h00, 1, -1, 1'b0, -1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    check_frame_seq("b", 8'h00);
    check("b_done_cnt", 32'(done_cnt), 32'd1);

    // Early frame end on pixel (2,1), then a full frame.
    clear_stats();
    stream(8'h00, 0, 9, 1'b1, -1);
    check("c_count", 32'(got_q.size()), 32'd2);
    if (got_q.size() == 2) check("c_last", 32'(got_q[1]), 32'h011121);
    check("c_done_cnt", 32'(done_cnt), 32'd1);
    clear_stats();
    stream(8'h00, 0, -1, 1'b0, -1);
    check_frame_seq("c2", 8'h00);

    // Reset after pixel (2,2), then a new frame offset by 0x80.
    stream(8'h00, 0, 10, 1'b0, -1);
    cyc(1'b1, 1'b0, 8'hCC, 1'b1);
    clear_stats();
    stream(8'h80, 0, -1, 1'b0, -1);
    check("d_count", 32'(got_q.size()), 32'd8);
    if (got_q.size() > 0) check("d_first", 32'(got_q[0]), 32'h8090A0);

    // Two frames back to back with no idle cycle.
    clear_stats();
    stream(8'h00, 0, -1, 1'b0, -1);
    stream(8'h40, 0, -1, 1'b0, -1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    check("e_count", 32'(got_q.size()), 32'd16);
    check("e_done_cnt", 32'(done_cnt), 32'd2);
    if (got_q.size() == 16) check("e_f2_first", 32'(got_q[8]), 32'h405060);

    // i_done with i_valid=0 mid-row must be ignored.
    clear_stats();
    stream(8'h00, 0, -1, 1'b0, 5);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    check_frame_seq("f", 8'h00);
    check("f_done_cnt", 32'(done_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_line_buffer.md
CONV_LINE_BUFFER -- requirements
Module: conv_line_buffer

Interface
REQ-001 Parameter IMG_WIDTH, default 320, pixels per image row (minimum 2).
REQ-002 Parameter IMG_HEIGHT, default 240, rows per image (minimum 3).
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port i_valid  input  1  i_data carries one raster-order pixel this cycle.
REQ-006 Port i_done  input  1  marks the final pixel of the current image; qualified by i_valid.
REQ-007 Port i_data  input  8  unsigned pixel, raster order (row-major, left to right).
REQ-008 Port o_valid  output  1  o_data holds one valid 3-row column this cycle.
REQ-009 Port o_img_done  output  1  single-cycle end-of-image pulse for the downstream 3x3 convolution.
REQ-010 Port o_data  output  24  column vector: [23:16] row r-2, [15:8] row r-1, [7:0] row r, all at column c.

Function
REQ-011 The block SHALL keep column counter col (0..IMG_WIDTH-1) and row counter row (0..IMG_HEIGHT-1), both advancing only on cycles with i_valid=1.
REQ-012 On an accepted pixel, col SHALL increment; at col=IMG_WIDTH-1 it SHALL wrap to 0 and row SHALL increment.
REQ-013 Row wraps to 0 after row=IMG_HEIGHT-1, col=IMG_WIDTH-1, i.e. frames are implicitly delimited by pixel count.
REQ-014 An accepted pixel with i_done=1 SHALL force col and row to 0 for the next pixel, regardless of current position (early frame end).
REQ-015 i_done with i_valid=0 SHALL be ignored.
REQ-016 The block SHALL hold two line memories, line1 (row r-1) and line2 (row r-2), each IMG_WIDTH x 8 bits, indexed by col.
REQ-017 On an accepted pixel at column c: read line2[c] and line1[c] before write; write line2[c] <= old line1[c] and line1[c] <= i_data in the same cycle.
REQ-018 Output latency SHALL be exactly 1 cycle: o_data registered = {old line2[c], old line1[c], i_data}.
REQ-019 o_valid SHALL be 1 one cycle after an accepted pixel with row >= 2, else 0; rows 0 and 1 only prime the line memories.
REQ-020 o_img_done SHALL pulse 1 one cycle after an accepted pixel that has i_done=1 or is at (IMG_HEIGHT-1, IMG_WIDTH-1); pulse is not gated by o_valid.
REQ-021 When i_valid=0, o_valid and o_img_done SHALL be 0 next cycle and o_data SHALL hold its previous value; counters and memories unchanged.
REQ-022 Back-to-back frames with no idle cycle SHALL be supported; stale line data from the previous frame is never flagged valid because of REQ-019.
REQ-023 Throughput SHALL be one pixel per cycle sustained with no backpressure (downstream always accepts).

Reset
REQ-024 While reset=1 on a clock edge: col=0, row=0, o_valid=0, o_img_done=0, o_data=0.
REQ-025 Line memory contents SHALL NOT be cleared by reset; the row>=2 gate alone guarantees no stale output.
REQ-026 Reset asserted mid-frame SHALL abandon that frame; the first pixel accepted after reset deassertion is treated as row 0, col 0.
REQ-027 Input pixels presented in a cycle with reset=1 SHALL be discarded.

Verification (IMG_WIDTH=4, IMG_HEIGHT=4, pixel value = 16*row + col)
REQ-028 Full frame streamed continuously -> o_valid high for 8 cycles starting 1 cycle after pixel (2,0); first o_data=0x001020, output for (2,1)=0x011121, last (3,3)=0x132333 with o_img_done=1 the same cycle.
REQ-029 Same frame with i_valid deasserted every other cycle -> identical o_data sequence, o_valid only following accepted pixels, o_data held during gaps.
REQ-030 i_done=1 on pixel (2,1) -> o_valid with 0x011121 and o_img_done=1 together; next frame's first pixel is treated as (0,0), no o_valid for its first 8 pixels.
REQ-031 Reset pulsed after pixel (2,2) then new frame with values +0x80 -> no output for 8 accepted pixels, then o_data=0x8090A0 for (2,0).
REQ-032 Two frames back-to-back without idle, IMG_HEIGHT*IMG_WIDTH pixels each, no i_done -> o_img_done pulses exactly twice, o_valid count = 16, second frame rows 0-1 produce no o_valid.
REQ-033 i_done=1 with i_valid=0 mid-row -> no o_img_done pulse, counters unaffected, subsequent outputs match REQ-028.
